logic_sweep_checker: RTL and testbench

LOGIC_SWEEP_CHECKER -- requirements
Module: logic_sweep_checker

---
 rtl/logic_sweep_checker.sv | 166 ++++++++++++++++
 tb/tb_logic_sweep_checker.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_sweep_checker.sv
// logic_sweep_checker
//   Exhaustively sweeps the N_IN-bit input space of an external combinational
//   block, holds each vector for SETTLE cycles, then compares the block's
//   N_OUT outputs against a truth table latched when the sweep starts.
//
// Ports
//   clk_i              : clock, rising edge
//   rst_i              : asynchronous active-high reset
//   start_i            : request a sweep (accepted only while idle)
//   exp_mask_i         : expected truth tables; output k, vector v -> bit k*2^N_IN+v
//   f_i                : outputs of the block under test
//   vec_o              : stimulus vector (MSB = first operand)
//   busy_o             : sweep in progress
//   done_o             : one-cycle pulse at end of sweep
//   pass_o             : last completed sweep had no mismatches
//   fail_cnt_o         : number of mismatching vectors
//   first_fail_valid_o : first_fail_vec_o holds a captured vector
//   first_fail_vec_o   : first mismatching vector
//   mismatch_o         : one-cycle pulse on each failing compare
module logic_sweep_checker #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [N_OUT*(1<<N_IN)-1:0]   exp_mask_i,
  input  logic [N_OUT-1:0]             f_i,
  output logic [N_IN-1:0]              vec_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         pass_o,
  output logic [N_IN:0]                fail_cnt_o,
  output logic                         first_fail_valid_o,
  output logic [N_IN-1:0]              first_fail_vec_o,
  output logic                         mismatch_o
);

  localparam int NV = 1 << N_IN;
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [3:0]      CNT_ONE     = 4'd1;
  localparam logic [N_IN-1:0] VEC_LAST    = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] VEC_ONE     = 1;
  localparam logic [N_IN:0]   FC_ONE      = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [N_IN-1:0]             vec_q, vec_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic [N_IN:0]               fail_cnt_q, fail_cnt_d;
  logic                        ffv_q, ffv_d;
  logic [N_IN-1:0]             ffvec_q, ffvec_d;
  logic                        pass_q, pass_d;
  logic                        latch_exp;
  logic [N_OUT-1:0][NV-1:0]    exp_q;
  logic [N_OUT-1:0]            exp_bits;
  logic                        miss;

  // Expected value of every output for the vector currently applied.
  for (genvar k = 0; k < N_OUT; k++) begin : g_exp
    assign exp_bits[k] = exp_q[k][vec_q];
  end

  assign miss = |(f_i ^ exp_bits);

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    fail_cnt_d = fail_cnt_q;
    ffv_d      = ffv_q;
    ffvec_d    = ffvec_q;
    pass_d     = pass_q;
    latch_exp  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          vec_d      = '0;
          cnt_d      = '0;
          fail_cnt_d = '0;
          ffv_d      = 1'b0;
          ffvec_d    = '0;
          pass_d     = 1'b0;
          latch_exp  = 1'b1;
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_CHECK: begin
        if (miss) begin
          fail_cnt_d = fail_cnt_q + FC_ONE;
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = vec_q;
          end
        end
        if (vec_q == VEC_LAST) begin
          // Verdict is formed on entry to DONE so it is valid alongside done_o,
          // and includes the result of this final compare.
          pass_d  = (fail_cnt_d == '0);
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + VEC_ONE;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      vec_q      <= '0;
      cnt_q      <= '0;
      fail_cnt_q <= '0;
      ffv_q      <= 1'b0;
      ffvec_q    <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      fail_cnt_q <= fail_cnt_d;
      ffv_q      <= ffv_d;
      ffvec_q    <= ffvec_d;
      pass_q     <= pass_d;
    end
  end

  // Truth table is pure data: captured at sweep start, no reset needed.
  always_ff @(posedge clk_i) begin
    if (latch_exp) begin
      exp_q <= exp_mask_i;
    end
  end

  assign vec_o              = vec_q;
  assign busy_o             = (state_q != ST_IDLE);
  assign done_o             = (state_q == ST_DONE);
  assign pass_o             = pass_q;
  assign fail_cnt_o         = fail_cnt_q;
  assign first_fail_valid_o = ffv_q;
  assign first_fail_vec_o   = ffvec_q;
  assign mismatch_o         = (state_q == ST_CHECK) && miss;

endmodule

// File: tb/tb_logic_sweep_checker.sv
module tb_logic_sweep_checker;

  typedef struct {
    int         e;      // clock edge index that accepts the start
    int         s;      // settle cycles
    logic [7:0] fv;     // failing vectors
    int         cnt;
    int         first;
    bit         ffv;
    bit         pass;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: default parameters
  logic        rst_a = 1'b1, start_a = 1'b0;
  logic [15:0] mask_a = 16'h0;
  logic [7:0]  tt0_a = 8'h0, tt1_a = 8'h0;
  logic [1:0]  f_a;
  logic [2:0]  vec_a, ffvec_a;
  logic        busy_a, done_a, pass_a, ffv_a, mm_a;
  logic [3:0]  fc_a;
  exp_t        q_a[$];

  assign f_a = {tt1_a[vec_a], tt0_a[vec_a]};

  logic_sweep_checker dut_a (
    .clk_i(clk), .rst_i(rst_a), .start_i(start_a), .exp_mask_i(mask_a), .f_i(f_a),
    .vec_o(vec_a), .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
    .fail_cnt_o(fc_a), .first_fail_valid_o(ffv_a), .first_fail_vec_o(ffvec_a),
    .mismatch_o(mm_a));

  // Instance B: SETTLE = 1
  logic        rst_b = 1'b1, start_b = 1'b0;
  logic [15:0] mask_b = 16'h0;
  logic [7:0]  tt0_b = 8'h0, tt1_b = 8'h0;
  logic [1:0]  f_b;
  logic [2:0]  vec_b, ffvec_b;
  logic        busy_b, done_b, pass_b, ffv_b, mm_b;
  logic [3:0]  fc_b;
  exp_t        q_b[$];

  assign f_b = {tt1_b[vec_b], tt0_b[vec_b]};

  logic_sweep_checker #(.N_IN(3), .N_OUT(2), .SETTLE(1)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .start_i(start_b), .exp_mask_i(mask_b), .f_i(f_b),
    .vec_o(vec_b), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
    .fail_cnt_o(fc_b), .first_fail_valid_o(ffv_b), .first_fail_vec_o(ffvec_b),
    .mismatch_o(mm_b));

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: a vector fails if any actual output differs from its table entry.
  function automatic exp_t model(input int e, input int s, input logic [15:0] m,
                                 input logic [7:0] t0, input logic [7:0] t1);
    exp_t r;
    logic [7:0] d;
    d       = (t0 ^ m[7:0]) | (t1 ^ m[15:8]);
    r.e     = e;
    r.s     = s;
    r.fv    = d;
    r.cnt   = $countones(d);
    r.pass  = (d == 8'h0);
    r.ffv   = (d != 8'h0);
    r.first = 0;
    for (int v = 7; v >= 0; v--) if (((d >> v) & 8'd1) != 8'd0) r.first = v;
    return r;
  endfunction

  task automatic mon(input string nm, input bit have, input exp_t E,
                     input logic [2:0] vec, input logic busy, input logic done,
                     input logic mm, input logic pass, input logic [3:0] fc,
                     input logic ffv, input logic [2:0] ffvec, output bit pop);
    int off, len, v;
    pop = 1'b0;
    if (!have) begin
      chk({nm, "_spurious_done"}, int'(done), 0);
      chk({nm, "_spurious_mismatch"}, int'(mm), 0);
    end else begin
      off = cyc - E.e;
      len = 8 * (E.s + 1);
      v   = (off >= 0) ? off / (E.s + 1) : 0;
      if (v > 7) v = 7;
      if (off >= 0 && off < len) begin
        chk({nm, "_busy"}, int'(busy), 1);
        chk({nm, "_vec"}, int'(vec), v);
        chk({nm, "_mismatch"}, int'(mm),
            ((off % (E.s + 1)) == E.s) ? int'((E.fv >> v) & 8'd1) : 0);
      end
      if (off == len) begin
        chk({nm, "_done_at_cycle"}, int'(done), 1);
        chk({nm, "_vec_final"}, int'(vec), 7);
        chk({nm, "_pass"}, int'(pass), int'(E.pass));
        chk({nm, "_fail_cnt"}, int'(fc), E.cnt);
        chk({nm, "_ff_valid"}, int'(ffv), int'(E.ffv));
        chk({nm, "_ff_vec"}, int'(ffvec), E.first);
        pop = 1'b1;
      end else begin
        chk({nm, "_early_done"}, int'(done), 0);
      end
    end
  endtask

  // Monitor: compares DUT against queued expectations on the falling edge.
  always @(negedge clk) begin
    exp_t ea, eb;
    bit   pa, pb;
    ea = '{default: 0};
    eb = '{default: 0};
    if (q_a.size() > 0) ea = q_a[0];
    if (q_b.size() > 0) eb = q_b[0];
    mon("a", q_a.size() > 0, ea, vec_a, busy_a, done_a, mm_a, pass_a, fc_a, ffv_a, ffvec_a, pa);
    mon("b", q_b.size() > 0, eb, vec_b, busy_b, done_b, mm_b, pass_b, fc_b, ffv_b, ffvec_b, pb);
    if (pa) void'(q_a.pop_front());
    if (pb) void'(q_b.pop_front());
  end

  task automatic start_a_pulse(input logic [15:0] m, input logic [7:0] t0, input logic [7:0] t1);
    @(negedge clk); #1;
    mask_a = m; tt0_a = t0; tt1_a = t1; start_a = 1'b1;
    q_a.push_back(model(cyc + 1, 2, m, t0, t1));
    @(negedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic wait_idle_a();
    int i;
    for (i = 0; i < 300 && (q_a.size() != 0 || busy_a); i++) @(negedge clk);
    chk("a_sweep_timeout", q_a.size(), 0);
  endtask

  task automatic wait_idle_b();
    int i;
    for (i = 0; i < 300 && (q_b.size() != 0 || busy_b); i++) @(negedge clk);
    chk("b_sweep_timeout", q_b.size(), 0);
  endtask

  task automatic chk_zero_a(input string nm);
    chk({nm, "_vec"}, int'(vec_a), 0);
    chk({nm, "_busy"}, int'(busy_a), 0);
    chk({nm, "_done"}, int'(done_a), 0);
    chk({nm, "_pass"}, int'(pass_a), 0);
    chk({nm, "_fail_cnt"}, int'(fc_a), 0);
    chk({nm, "_ff_valid"}, int'(ffv_a), 0);
    chk({nm, "_ff_vec"}, int'(ffvec_a), 0);
    chk({nm, "_mismatch"}, int'(mm_a), 0);
  endtask

  localparam logic [15:0] GOOD = {8'h74, 8'hE4};

  initial begin
    logic [15:0] m;
    logic [7:0]  t0, t1;
    int          e0, dcnt, i;

    // Reset state, and start_i ignored while reset is high
    repeat (3) @(negedge clk);
    chk_zero_a("a_reset");
    chk("b_reset_busy", int'(busy_b), 0);
    chk("b_reset_fail_cnt", int'(fc_b), 0);
    #1 start_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("a_start_in_reset_busy", int'(busy_a), 0);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    mask_a = GOOD; tt0_a = 8'hE4; tt1_a = 8'h74;
    q_a.push_back(model(cyc + 1, 2, GOOD, 8'hE4, 8'h74));
    @(negedge clk); #1;
    start_a = 1'b0;
    wait_idle_a();

    // Correct block, plain start pulse
    start_a_pulse(GOOD, 8'hE4, 8'h74);
    wait_idle_a();
    // F2 stuck at 0
    start_a_pulse(GOOD, 8'hE4, 8'h00);
    wait_idle_a();
    chk("a_hold_fail_cnt", int'(fc_a), 4);
    // F1 inverted at vector 7 only
    start_a_pulse(GOOD, 8'hE4 ^ 8'h80, 8'h74);
    wait_idle_a();

    // Random tables and random sparse faults
    for (int k = 0; k < 8; k++) begin
      m  = 16'($urandom);
      t0 = m[7:0]  ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      t1 = m[15:8] ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      start_a_pulse(m, t0, t1);
      wait_idle_a();
    end

    // Asynchronous reset mid-sweep while vec_o == 3
    start_a_pulse(GOOD, 8'hE4, 8'h00);
    for (i = 0; i < 40 && vec_a != 3'd3; i++) @(negedge clk);
    chk("a_reach_vec3", int'(vec_a), 3);
    #2;
    rst_a = 1'b1;
    q_a.delete();
    #1;
    chk_zero_a("a_async_reset");
    repeat (4) @(negedge clk);
    chk("a_reset_hold_busy", int'(busy_a), 0);
    #1 rst_a = 1'b0;
    start_a_pulse(GOOD, 8'hE4, 8'h00);
    wait_idle_a();

    // start_i held high for 60 cycles: re-triggers after each return to idle
    @(negedge clk); #1;
    mask_a = GOOD; tt0_a = 8'hE4; tt1_a = 8'h00; start_a = 1'b1;
    e0 = cyc + 1;
    q_a.push_back(model(e0,      2, GOOD, 8'hE4, 8'h00));
    q_a.push_back(model(e0 + 26, 2, GOOD, 8'hE4, 8'h00));
    q_a.push_back(model(e0 + 52, 2, GOOD, 8'hE4, 8'h00));
    dcnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done_a) dcnt++;
      if (cyc == e0 + 24) chk("a_held_busy_in_done", int'(busy_a), 1);
      if (cyc == e0 + 25) begin
        chk("a_held_gap_busy", int'(busy_a), 0);
        chk("a_held_gap_fail_cnt", int'(fc_a), 4);
        chk("a_held_gap_ff_valid", int'(ffv_a), 1);
      end
      if (cyc == e0 + 26) begin
        chk("a_held_restart_busy", int'(busy_a), 1);
        chk("a_held_cleared_fail_cnt", int'(fc_a), 0);
        chk("a_held_cleared_ff_valid", int'(ffv_a), 0);
        chk("a_held_cleared_pass", int'(pass_a), 0);
      end
      if (cyc == e0 + 51) chk("a_held_gap2_busy", int'(busy_a), 0);
    end
    #1 start_a = 1'b0;
    chk("a_held_done_pulses", dcnt, 2);
    wait_idle_a();

    // SETTLE = 1 with the mask changed mid-sweep
    for (int k = 0; k < 5; k++) begin
      m  = (k == 0) ? GOOD : 16'($urandom);
      t0 = m[7:0]  ^ ((k == 0) ? 8'h00 : (8'($urandom) & 8'($urandom)));
      t1 = m[15:8] ^ ((k == 0) ? 8'h00 : (8'($urandom) & 8'($urandom)));
      @(negedge clk); #1;
      mask_b = m; tt0_b = t0; tt1_b = t1; start_b = 1'b1;
      q_b.push_back(model(cyc + 1, 1, m, t0, t1));
      @(negedge clk); #1;
      start_b = 1'b0;
      repeat (4) @(negedge clk);
      #1 mask_b = ~m;
      wait_idle_b();
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
